// File: rtl/intr_nest_ctrl.sv
// rtl/intr_nest_ctrl.sv - nesting and acknowledge scheduler between intrcntrl and the CPU
module intr_nest_ctrl #(
   parameter int MAX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pic_int_req,
   output logic        pic_int_ack,
   input  logic [31:0] pic_data,
   output logic        cpu_irq,
   input  logic        cpu_ack,
   output logic [4:0]  cpu_vector,
   input  logic        eoi,
   output logic [31:0] isr,
   output logic [5:0]  depth,
   output logic        pend_valid
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_CAPT,
      ST_PRESENT
   } state_t;

   localparam logic [5:0] LP_MAX_DEPTH = 6'(MAX_DEPTH);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_isr;
   logic [5:0]  r_depth;
   logic [4:0]  r_cand;
   logic [4:0]  r_pend;
   logic        r_pend_valid;

   logic [4:0]  w_cand_nxt;
   logic [4:0]  w_pend_nxt;
   logic        w_pend_valid_nxt;
   logic        w_accept;
   logic [4:0]  w_top;
   logic        w_isr_nz;
   logic        w_pend_hi;
   logic        w_capt_hi;
   logic        w_room;
   logic        w_eoi_clr;
   logic [31:0] w_clr_mask;
   logic [31:0] w_set_mask;
   logic [31:0] w_isr_nxt;
   logic [5:0]  w_depth_nxt;
   logic        w_data_unused;

   // Upper data bus bits carry nothing for us
   assign w_data_unused = ^pic_data[31:5];

   // Highest set ISR bit; meaningful only when the ISR is non-zero
   always_comb begin
      w_top = '0;
      for (int i = 0; i < 32; i++) begin
         if (r_isr[i]) w_top = 5'(i);
      end
   end

   // An empty ISR behaves as top = -1, so every source outranks it
   assign w_isr_nz  = |r_isr;
   assign w_pend_hi = !w_isr_nz || (r_pend > w_top);
   assign w_capt_hi = !w_isr_nz || (pic_data[4:0] > w_top);
   assign w_room    = r_depth < LP_MAX_DEPTH;

   // Next-state and candidate/pending slot decisions
   always_comb begin
      w_state_nxt      = r_state;
      w_cand_nxt       = r_cand;
      w_pend_nxt       = r_pend;
      w_pend_valid_nxt = r_pend_valid;
      w_accept         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pend_valid && w_pend_hi && w_room) begin
               w_cand_nxt       = r_pend;
               w_pend_valid_nxt = 1'b0;
               w_state_nxt      = ST_PRESENT;
            end else if (pic_int_req && !r_pend_valid && w_room) begin
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            w_state_nxt = ST_CAPT;
         end
         ST_CAPT: begin
            w_cand_nxt = pic_data[4:0];
            if (w_capt_hi) begin
               w_state_nxt = ST_PRESENT;
            end else begin
               w_pend_nxt       = pic_data[4:0];
               w_pend_valid_nxt = 1'b1;
               w_state_nxt      = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (cpu_ack) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // EOI clears the old top before the accepted vector is set
   assign w_eoi_clr  = eoi && w_isr_nz;
   assign w_clr_mask = w_eoi_clr ? (32'd1 << w_top) : 32'd0;
   assign w_set_mask = w_accept ? (32'd1 << r_cand) : 32'd0;
   assign w_isr_nxt  = (r_isr & ~w_clr_mask) | w_set_mask;

   // Depth tracks the ISR population; simultaneous set and clear cancel
   always_comb begin
      w_depth_nxt = r_depth;
      if (w_accept && !w_eoi_clr) w_depth_nxt = r_depth + 6'd1;
      else if (!w_accept && w_eoi_clr) w_depth_nxt = r_depth - 6'd1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // In-service, depth, candidate and pending registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_isr        <= '0;
         r_depth      <= '0;
         r_cand       <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         r_isr        <= w_isr_nxt;
         r_depth      <= w_depth_nxt;
         r_cand       <= w_cand_nxt;
         r_pend       <= w_pend_nxt;
         r_pend_valid <= w_pend_valid_nxt;
      end
   end

   assign pic_int_ack = (r_state == ST_ACK);
   assign cpu_irq     = (r_state == ST_PRESENT);
   assign cpu_vector  = cpu_irq ? r_cand : 5'd0;
   assign isr         = r_isr;
   assign depth       = r_depth;
   assign pend_valid  = r_pend_valid;

endmodule

// File: tb/tb_intr_nest_ctrl.sv
// tb/tb_intr_nest_ctrl.sv - directed self-checking bench for intr_nest_ctrl
module tb_intr_nest_ctrl;

   logic        clk;
   logic        reset;
   logic        pic_int_req;
   logic [31:0] pic_data;
   logic        cpu_ack;
   logic        eoi;

   logic        pic_int_ack;
   logic        cpu_irq;
   logic [4:0]  cpu_vector;
   logic [31:0] isr;
   logic [5:0]  depth;
   logic        pend_valid;

   logic        d2_pic_int_ack;
   logic        d2_cpu_irq;
   logic [4:0]  d2_cpu_vector;
   logic [31:0] d2_isr;
   logic [5:0]  d2_depth;
   logic        d2_pend_valid;

   int n_checks;
   int n_errors;

   intr_nest_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .pic_int_req (pic_int_req),
      .pic_int_ack (pic_int_ack),
      .pic_data    (pic_data),
      .cpu_irq     (cpu_irq),
      .cpu_ack     (cpu_ack),
      .cpu_vector  (cpu_vector),
      .eoi         (eoi),
      .isr         (isr),
      .depth       (depth),
      .pend_valid  (pend_valid)
   );

   intr_nest_ctrl #(.MAX_DEPTH(2)) u_dut_d2 (
      .clk         (clk),
      .reset       (reset),
      .pic_int_req (pic_int_req),
      .pic_int_ack (d2_pic_int_ack),
      .pic_data    (pic_data),
      .cpu_irq     (d2_cpu_irq),
      .cpu_ack     (cpu_ack),
      .cpu_vector  (d2_cpu_vector),
      .eoi         (eoi),
      .isr         (d2_isr),
      .depth       (d2_depth),
      .pend_valid  (d2_pend_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Full handshake for one source that outranks the ISR, then CPU accept
   task automatic serve(input logic [4:0] src);
      pic_int_req = 1'b1;
      pic_data    = {27'd0, src};
      step();
      pic_int_req = 1'b0;
      step();
      step();
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b1;
      pic_int_req = 1'b0;
      pic_data    = 32'd0;
      cpu_ack     = 1'b0;
      eoi         = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check_eq("rst_ack",   {31'd0, pic_int_ack}, 32'd0);
      check_eq("rst_irq",   {31'd0, cpu_irq},     32'd0);
      check_eq("rst_vec",   {27'd0, cpu_vector},  32'd0);
      check_eq("rst_isr",   isr,                  32'd0);
      check_eq("rst_depth", {26'd0, depth},       32'd0);
      check_eq("rst_pend",  {31'd0, pend_valid},  32'd0);

      // Source 31 on an idle ISR; request drop after the ack is ignored
      pic_int_req = 1'b1;
      pic_data    = 32'hFFFF_FFFF;
      step();
      check_eq("t1_ack_hi", {31'd0, pic_int_ack}, 32'd1);
      check_eq("t1_irq_lo", {31'd0, cpu_irq},     32'd0);
      pic_int_req = 1'b0;
      step();
      check_eq("t1_ack_lo", {31'd0, pic_int_ack}, 32'd0);
      check_eq("t1_irq_lo2", {31'd0, cpu_irq},    32'd0);
      step();
      check_eq("t1_irq_hi", {31'd0, cpu_irq},     32'd1);
      check_eq("t1_vec",    {27'd0, cpu_vector},  32'd31);
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
      check_eq("t1_isr",    isr,                  32'h8000_0000);
      check_eq("t1_depth",  {26'd0, depth},       32'd1);
      check_eq("t1_irq_off", {31'd0, cpu_irq},    32'd0);

      // Nesting: 14 in service, 30 nests, 13 goes to the pending slot
      do_reset();
      serve(5'd14);
      check_eq("t2_isr14", isr, 32'h0000_4000);
      serve(5'd30);
      check_eq("t2_isr",   isr,            32'h4000_4000);
      check_eq("t2_depth", {26'd0, depth}, 32'd2);
      pic_int_req = 1'b1;
      pic_data    = 32'd13;
      step();
      check_eq("t2_ack13", {31'd0, pic_int_ack}, 32'd1);
      step();
      step();
      check_eq("t2_pend",  {31'd0, pend_valid}, 32'd1);
      check_eq("t2_irq",   {31'd0, cpu_irq},    32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t2_noack", {31'd0, pic_int_ack}, 32'd0);
         check_eq("t2_noirq", {31'd0, cpu_irq},     32'd0);
      end
      pic_int_req = 1'b0;

      // Two EOIs release the pending 13
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      check_eq("t3_isr_a",   isr,            32'h0000_4000);
      check_eq("t3_depth_a", {26'd0, depth}, 32'd1);
      step();
      check_eq("t3_irq_a",   {31'd0, cpu_irq}, 32'd0);
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      check_eq("t3_isr_b",   isr,               32'd0);
      check_eq("t3_depth_b", {26'd0, depth},    32'd0);
      check_eq("t3_irq_b",   {31'd0, cpu_irq},  32'd0);
      check_eq("t3_pend_b",  {31'd0, pend_valid}, 32'd1);
      step();
      check_eq("t3_irq_rel", {31'd0, cpu_irq},  32'd1);
      check_eq("t3_vec_rel", {27'd0, cpu_vector}, 32'd13);
      check_eq("t3_pend_rel", {31'd0, pend_valid}, 32'd0);
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
      check_eq("t3_isr_c",   isr,            32'h0000_2000);
      check_eq("t3_depth_c", {26'd0, depth}, 32'd1);

      // Depth limit of 2 blocks the acknowledge until an EOI
      do_reset();
      serve(5'd5);
      serve(5'd10);
      check_eq("t4_depth", {26'd0, d2_depth}, 32'd2);
      pic_int_req = 1'b1;
      pic_data    = 32'd20;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t4_blocked", {31'd0, d2_pic_int_ack}, 32'd0);
      end
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      check_eq("t4_depth_eoi", {26'd0, d2_depth},      32'd1);
      check_eq("t4_isr_eoi",   d2_isr,                 32'h0000_0020);
      check_eq("t4_ack_eoi",   {31'd0, d2_pic_int_ack}, 32'd0);
      step();
      check_eq("t4_ack_next",  {31'd0, d2_pic_int_ack}, 32'd1);
      pic_int_req = 1'b0;

      // EOI coinciding with CPU accept
      do_reset();
      serve(5'd6);
      pic_int_req = 1'b1;
      pic_data    = 32'd9;
      step();
      pic_int_req = 1'b0;
      step();
      step();
      check_eq("t5_vec", {27'd0, cpu_vector}, 32'd9);
      eoi     = 1'b1;
      cpu_ack = 1'b1;
      step();
      eoi     = 1'b0;
      cpu_ack = 1'b0;
      check_eq("t5_isr",   isr,            32'h0000_0200);
      check_eq("t5_depth", {26'd0, depth}, 32'd1);

      // EOI on an empty ISR changes nothing
      do_reset();
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      check_eq("t5_eoi0_isr",   isr,            32'd0);
      check_eq("t5_eoi0_depth", {26'd0, depth}, 32'd0);

      // Reset in CAPT abandons the handshake
      pic_int_req = 1'b1;
      pic_data    = 32'd20;
      step();
      pic_int_req = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("t6c_ack", {31'd0, pic_int_ack}, 32'd0);
      check_eq("t6c_irq", {31'd0, cpu_irq},     32'd0);
      step();
      check_eq("t6c_irq2", {31'd0, cpu_irq},    32'd0);

      // Reset in PRESENT
      pic_int_req = 1'b1;
      pic_data    = 32'd12;
      step();
      pic_int_req = 1'b0;
      step();
      step();
      check_eq("t6p_irq_pre", {31'd0, cpu_irq}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("t6p_irq", {31'd0, cpu_irq},    32'd0);
      check_eq("t6p_vec", {27'd0, cpu_vector}, 32'd0);
      check_eq("t6p_isr", isr,                 32'd0);

      // Reset clears an occupied pending slot
      serve(5'd25);
      pic_int_req = 1'b1;
      pic_data    = 32'd3;
      step();
      pic_int_req = 1'b0;
      step();
      step();
      check_eq("t6q_pend_set", {31'd0, pend_valid}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("t6q_pend", {31'd0, pend_valid}, 32'd0);
      check_eq("t6q_isr",  isr,                 32'd0);
      check_eq("t6q_depth", {26'd0, depth},     32'd0);
      step();
      check_eq("t6q_irq", {31'd0, cpu_irq},     32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/intr_nest_ctrl.md
# intr_nest_ctrl

Nesting and acknowledge scheduler between the 32-source fixed-priority interrupt controller (`intrcntrl`) and the CPU. It runs the acknowledge handshake with `intrcntrl` and captures the served source number. It keeps a 32-bit in-service register (ISR) and presents a request to the CPU only if it outranks every in-service source (31 highest, 0 lowest). A captured lower-priority request is held in a one-entry pending slot until end-of-interrupt (EOI) lets it through.

## Interface
- MAX_DEPTH, 4, maximum number of simultaneously in-service sources (1..32).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pic_int_req  in  1  request from `intrcntrl` (its `int_req`).
- pic_int_ack  out  1  acknowledge to `intrcntrl` (its `int_ack`); one-cycle pulse.
- pic_data  in  32  `intrcntrl` data bus; source number on [4:0] in the cycle after `pic_int_ack` is sampled; [31:5] ignored.
- cpu_irq  out  1  interrupt to CPU; level, held until `cpu_ack`.
- cpu_ack  in  1  CPU accepts the presented vector.
- cpu_vector  out  5  source number presented with `cpu_irq`.
- eoi  in  1  non-specific end-of-interrupt pulse.
- isr  out  32  in-service register.
- depth  out  6  number of set ISR bits.
- pend_valid  out  1  pending slot occupied.

## Operation
- `top` is the index of the highest set ISR bit. If the ISR is zero, `top` is -1, so any source qualifies.
- Registered FSM with states IDLE, ACK, CAPT and PRESENT. Outputs decode from registered state.
- IDLE, checked in priority order:
  - (a) If `pend_valid`, `pend > top` and `depth < MAX_DEPTH`: load `cand = pend`, clear `pend_valid`, go to PRESENT.
  - (b) Else if `pic_int_req`, `!pend_valid` and `depth < MAX_DEPTH`: go to ACK.
  - (c) Else stay in IDLE.
- ACK: `pic_int_ack = 1` for exactly this cycle, then go to CAPT unconditionally. A `pic_int_req` drop is ignored.
- CAPT: `cand = pic_data[4:0]`.
  - If `cand > top`, go to PRESENT.
  - Otherwise set `pend = cand`, `pend_valid = 1`, and go to IDLE. This includes `cand` equal to an in-service bit.
- PRESENT: `cpu_irq = 1` and `cpu_vector = cand`. On `cpu_ack`: set `isr[cand]`, increment `depth`, go to IDLE. `cpu_ack` outside PRESENT is ignored.
- EOI, accepted in any state:
  - Clears `isr[top]` and decrements `depth`.
  - Ignored when the ISR is zero.
  - If it coincides with `cpu_ack`, clear the highest bit of the pre-update ISR first, then set `isr[cand]`. `depth` is then unchanged.
- `cand` is not re-checked while in PRESENT. A request committed to the CPU is never withdrawn.
- Reset, including mid-handshake, sets the state to IDLE.
  - Outputs return to reset values: `pic_int_ack = 0`, `cpu_irq = 0`, `cpu_vector = 0`, `isr = 0`, `depth = 0`, `pend_valid = 0`.
  - `pend` and `cand` are cleared to 0.
  - An in-flight acknowledge is abandoned.

## Timing
- Edge N samples IDLE with `pic_int_req = 1` (case b). `pic_int_ack` is high from N to N+1.
- `intrcntrl` samples the ack at N+1 and drives `pic_data` during N+1 to N+2.
- Edge N+2 captures `pic_data`. `cpu_irq` is high from N+2. Request-to-`cpu_irq` latency is 2 cycles after the sampling edge.
- Pending release (case a): `cpu_irq` rises one edge after the EOI edge that makes `pend > top`.
- Minimum spacing between two `pic_int_ack` pulses is 4 cycles: ACK, CAPT, PRESENT, then at least one IDLE cycle.
- `depth == MAX_DEPTH` blocks both new acknowledges and pending release until an EOI.

## Test plan
- Idle ISR, `intrcntrl` serves source 31 -> `pic_int_ack` pulses 1 cycle; `cpu_irq = 1` with `cpu_vector = 31` 2 edges later; `cpu_ack` -> `isr = 0x8000_0000`, `depth = 1`.
- ISR bit 14 set; source 30 then source 13 served -> 30 presented (nested, `depth = 2`); 13 captured into pending (`pend_valid = 1`) and `cpu_irq` stays 0; no further `pic_int_ack` while pending.
- From the previous state, two EOIs -> first clears bit 30, second clears bit 14; `cpu_irq` rises with `cpu_vector = 13` one edge after the second EOI.
- MAX_DEPTH = 2 with 2 sources in service and `pic_int_req = 1` -> `pic_int_ack` stays 0 until EOI; after EOI `depth = 1` and the ack issues next cycle.
- `eoi` and `cpu_ack` in the same cycle with `isr` bit 6 set and `cand = 9` -> `isr` becomes bit 9 only, `depth` unchanged. `eoi` with `isr = 0` -> no change.
- `reset` asserted in CAPT and in PRESENT -> next cycle all outputs at reset values and state IDLE; pending slot cleared.
